avalon_bus_arbiter: RTL and testbench

//  2:1 Avalon-MM pipelined arbiter; shares one memory port between core instruction bus (m0) and data bus (m1).

---
 rtl/avalon_bus_arbiter_if.sv | 63 ++++++
 rtl/avalon_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_avalon_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module  : avalon_bus_arbiter_if
//  Brief   : Bundle of the two master-side Avalon-MM ports (m0 ibus, m1 dbus)
//            and the shared slave-side memory port of the 2:1 arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
interface avalon_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            m0_read;
    logic            m0_write;
    logic [AW-1:0]   m0_address;
    logic [DW-1:0]   m0_writedata;
    logic [DW/8-1:0] m0_byteenable;
    logic            m0_waitrequest;
    logic [DW-1:0]   m0_readdata;
    logic            m0_readdatavalid;

    logic            m1_read;
    logic            m1_write;
    logic [AW-1:0]   m1_address;
    logic [DW-1:0]   m1_writedata;
    logic [DW/8-1:0] m1_byteenable;
    logic            m1_waitrequest;
    logic [DW-1:0]   m1_readdata;
    logic            m1_readdatavalid;

    logic            s_read;
    logic            s_write;
    logic [AW-1:0]   s_address;
    logic [DW-1:0]   s_writedata;
    logic [DW/8-1:0] s_byteenable;
    logic            s_waitrequest;
    logic [DW-1:0]   s_readdata;
    logic            s_readdatavalid;

    logic            err_unexp_rsp;

    // master: the arbiter's view (it masters the memory port)
    modport master (
        input  m0_read, m0_write, m0_address, m0_writedata, m0_byteenable,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_read, m1_write, m1_address, m1_writedata, m1_byteenable,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output s_read, s_write, s_address, s_writedata, s_byteenable,
        input  s_waitrequest, s_readdata, s_readdatavalid,
        output err_unexp_rsp
    );

    // slave: the surrounding system's view (core masters plus memory)
    modport slave (
        output m0_read, m0_write, m0_address, m0_writedata, m0_byteenable,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_read, m1_write, m1_address, m1_writedata, m1_byteenable,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  s_read, s_write, s_address, s_writedata, s_byteenable,
        output s_waitrequest, s_readdata, s_readdatavalid,
        input  err_unexp_rsp
    );
endinterface
`default_nettype wire

// File: rtl/avalon_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : avalon_bus_arbiter
//  Brief   : 2:1 round-robin Avalon-MM pipelined arbiter with command lock and
//            in-order read-response routing through an ID FIFO.
//  Rev     : 1.0  initial release
// ============================================================================
module avalon_bus_arbiter #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    avalon_bus_arbiter_if.master    bus
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_MAX = CW'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_locked_id, w_locked_id_nxt;
    logic            r_last_grant;
    logic            r_err;
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_ids [MAX_OUTSTANDING];

    logic            w_req0, w_req1;
    logic            w_gnt_vld, w_gnt;
    logic            w_g_read, w_g_write;
    logic            w_blocked, w_issue;
    logic            w_s_read, w_s_write, w_accept;
    logic            w_empty, w_pop, w_push, w_read_ok, w_head;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;
    logic [DW/8-1:0] w_be;

    assign w_req0    = bus.m0_read | bus.m0_write;
    assign w_req1    = bus.m1_read | bus.m1_write;
    assign w_empty   = (r_count == '0);
    assign w_pop     = bus.s_readdatavalid & ~w_empty;
    assign w_read_ok = (r_count != C_MAX) | w_pop;
    assign w_head    = r_ids[r_rd_ptr];

    always_comb begin
        w_gnt_vld       = 1'b0;
        w_gnt           = 1'b0;
        w_state_nxt     = r_state;
        w_locked_id_nxt = r_locked_id;

        // A command stalled by the slave keeps the bus until it is accepted.
        if (r_state == ST_LOCK) begin
            w_gnt_vld = 1'b1;
            w_gnt     = r_locked_id;
        end else if (w_req0 && w_req1) begin
            w_gnt_vld = 1'b1;
            w_gnt     = ~r_last_grant;
        end else if (w_req0) begin
            w_gnt_vld = 1'b1;
            w_gnt     = 1'b0;
        end else if (w_req1) begin
            w_gnt_vld = 1'b1;
            w_gnt     = 1'b1;
        end

        w_g_read  = w_gnt ? bus.m1_read      : bus.m0_read;
        w_g_write = w_gnt ? bus.m1_write     : bus.m0_write;
        w_addr    = w_gnt ? bus.m1_address   : bus.m0_address;
        w_wdata   = w_gnt ? bus.m1_writedata : bus.m0_writedata;
        w_be      = w_gnt ? bus.m1_byteenable: bus.m0_byteenable;

        w_blocked = w_gnt_vld & w_g_read & ~w_read_ok;
        w_issue   = w_gnt_vld & ~w_blocked;
        w_s_read  = w_issue & w_g_read;
        w_s_write = w_issue & w_g_write;
        w_accept  = (w_s_read | w_s_write) & ~bus.s_waitrequest;

        if (w_accept) begin
            w_state_nxt = ST_IDLE;
        end else if (w_s_read || w_s_write) begin
            w_state_nxt     = ST_LOCK;
            w_locked_id_nxt = w_gnt;
        end
    end

    assign w_push = w_accept & w_s_read;

    assign bus.s_read       = w_s_read;
    assign bus.s_write      = w_s_write;
    assign bus.s_address    = w_addr;
    assign bus.s_writedata  = w_wdata;
    assign bus.s_byteenable = w_be;

    assign bus.m0_waitrequest   = (w_issue && !w_gnt) ? bus.s_waitrequest : 1'b1;
    assign bus.m1_waitrequest   = (w_issue &&  w_gnt) ? bus.s_waitrequest : 1'b1;
    assign bus.m0_readdata      = bus.s_readdata;
    assign bus.m1_readdata      = bus.s_readdata;
    assign bus.m0_readdatavalid = w_pop & ~w_head;
    assign bus.m1_readdatavalid = w_pop &  w_head;
    assign bus.err_unexp_rsp    = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_locked_id  <= 1'b0;
            r_last_grant <= 1'b1;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_locked_id <= w_locked_id_nxt;
            if (w_accept)
                r_last_grant <= w_gnt;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);
            if (bus.s_readdatavalid && w_empty)
                r_err <= 1'b1;
        end
    end

    // ID storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (w_push)
            r_ids[r_wr_ptr] <= w_gnt;
    end
endmodule
`default_nettype wire

// File: tb/tb_avalon_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_avalon_bus_arbiter
//  Brief   : Self-checking bench for avalon_bus_arbiter with a response
//            scoreboard and a simple in-order memory slave model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_avalon_bus_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    avalon_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    avalon_bus_arbiter #(
        .AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    logic [AW-1:0] slv_q[$];
    bit            auto_rsp = 1'b0;
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic logic [DW-1:0] rdat(input logic [AW-1:0] a);
        return a + 32'h0000_C9FE;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Memory slave model plus response monitor, both mid-cycle.
    always @(negedge clk) begin
        if (!rst && bus.s_read && !bus.s_waitrequest)
            slv_q.push_back(bus.s_address);
        if (bus.m0_readdatavalid || bus.m1_readdatavalid) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", {bus.m1_readdatavalid, bus.m0_readdatavalid}, 2'b00);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_route", {bus.m1_readdatavalid, bus.m0_readdatavalid},
                      e.id ? 2'b10 : 2'b01);
                check("rsp_data", e.id ? bus.m1_readdata : bus.m0_readdata, e.data);
            end
        end
    end

    task automatic step(input bit force_rsp);
        @(posedge clk);
        #1;
        if ((auto_rsp || force_rsp) && slv_q.size() > 0) begin
            bus.s_readdatavalid = 1'b1;
            bus.s_readdata      = rdat(slv_q.pop_front());
        end else begin
            bus.s_readdatavalid = 1'b0;
            bus.s_readdata      = '0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb_q.size() > 0; i++) begin
            step(1'b0);
            @(negedge clk);
            #1;
        end
        check("drain_sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       lg, g;
        logic [AW-1:0] a0, a1;
        int         k0, k1;

        bus.m0_read = 0; bus.m0_write = 0; bus.m0_address = '0;
        bus.m0_writedata = '0; bus.m0_byteenable = 4'hF;
        bus.m1_read = 0; bus.m1_write = 0; bus.m1_address = '0;
        bus.m1_writedata = '0; bus.m1_byteenable = 4'hF;
        bus.s_waitrequest = 0; bus.s_readdata = '0; bus.s_readdatavalid = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_read", bus.s_read, 0);
        check("rst_s_write", bus.s_write, 0);
        check("rst_rdv", {bus.m1_readdatavalid, bus.m0_readdatavalid}, 2'b00);
        check("rst_err", bus.err_unexp_rsp, 0);
        check("rst_m0_wait", bus.m0_waitrequest, 1);
        step(1'b0);
        rst = 1'b0;

        // Single m0 read, zero-latency grant, response to m0 only
        bus.m0_read = 1; bus.m0_address = 32'h100;
        @(negedge clk);
        check("t1_s_read", bus.s_read, 1);
        check("t1_addr", bus.s_address, 32'h100);
        check("t1_waits", {bus.m1_waitrequest, bus.m0_waitrequest}, 2'b10);
        sb_q.push_back('{1'b0, 32'h0000_CAFE});
        step(1'b1);
        bus.m0_read = 0;
        @(negedge clk);
        check("t1_rsp_m0", bus.m0_readdatavalid, 1);
        check("t1_rsp_m1", bus.m1_readdatavalid, 0);

        // Both masters read every cycle: alternating grants, in-order responses
        auto_rsp = 1'b1;
        lg = 1'b0; k0 = 0; k1 = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            a0 = 32'h200 + 32'(4 * k0);
            a1 = 32'h300 + 32'(4 * k1);
            bus.m0_read = 1; bus.m0_address = a0;
            bus.m1_read = 1; bus.m1_address = a1;
            @(negedge clk);
            g = ~lg;
            check("t2_addr", bus.s_address, g ? a1 : a0);
            check("t2_waits", {bus.m1_waitrequest, bus.m0_waitrequest}, g ? 2'b01 : 2'b10);
            sb_q.push_back('{g, rdat(g ? a1 : a0)});
            if (g) k1++; else k0++;
            lg = g;
        end
        step(1'b0);
        bus.m0_read = 0;
        bus.m1_address = 32'h600;
        @(negedge clk);
        check("t2b_addr", bus.s_address, 32'h600);
        check("t2b_m1_wait", bus.m1_waitrequest, 0);
        sb_q.push_back('{1'b1, rdat(32'h600)});

        // m1 write stalled 3 cycles: lock holds it against a competing m0 read
        step(1'b0);
        bus.m1_read = 0; bus.m1_write = 1;
        bus.m1_address = 32'h400; bus.m1_writedata = 32'h1234_5678;
        bus.s_waitrequest = 1;
        @(negedge clk);
        check("t3_s_write", bus.s_write, 1);
        check("t3_m1_wait", bus.m1_waitrequest, 1);
        for (int c = 0; c < 2; c++) begin
            step(1'b0);
            bus.m0_read = 1; bus.m0_address = 32'h500;
            @(negedge clk);
            check("t3_lock_addr", bus.s_address, 32'h400);
            check("t3_lock_wdata", bus.s_writedata, 32'h1234_5678);
            check("t3_m0_wait", bus.m0_waitrequest, 1);
            check("t3_no_read", bus.s_read, 0);
        end
        step(1'b0);
        bus.s_waitrequest = 0;
        @(negedge clk);
        check("t3_acc_addr", bus.s_address, 32'h400);
        check("t3_acc_waits", {bus.m1_waitrequest, bus.m0_waitrequest}, 2'b01);
        step(1'b0);
        bus.m1_write = 0;
        @(negedge clk);
        check("t3_m0_addr", bus.s_address, 32'h500);
        check("t3_m0_go", bus.m0_waitrequest, 0);
        sb_q.push_back('{1'b0, rdat(32'h500)});
        step(1'b0);
        bus.m0_read = 0;
        drain();
        repeat (2) step(1'b0);

        // Fill the ID FIFO, then pop and push in the same cycle
        auto_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            bus.m0_read = 1; bus.m0_address = 32'h700 + 32'(4 * i);
            @(negedge clk);
            check("t4_fill_wait", bus.m0_waitrequest, 0);
            sb_q.push_back('{1'b0, rdat(32'h700 + 32'(4 * i))});
        end
        step(1'b0);
        bus.m0_address = 32'h710;
        @(negedge clk);
        check("t4_full_wait", bus.m0_waitrequest, 1);
        check("t4_full_s_read", bus.s_read, 0);
        step(1'b1);
        @(negedge clk);
        check("t4_pop_push_wait", bus.m0_waitrequest, 0);
        check("t4_pop_push_s_read", bus.s_read, 1);
        sb_q.push_back('{1'b0, rdat(32'h710)});
        step(1'b0);
        bus.m0_address = 32'h714;
        @(negedge clk);
        check("t4_still_full", bus.m0_waitrequest, 1);
        auto_rsp = 1'b1;
        step(1'b0);
        bus.m0_read = 0;
        drain();
        repeat (2) step(1'b0);

        // Unexpected response: dropped, sticky error, cleared by reset
        step(1'b0);
        bus.s_readdatavalid = 1; bus.s_readdata = 32'hBAD;
        @(negedge clk);
        check("t5_no_rdv", {bus.m1_readdatavalid, bus.m0_readdatavalid}, 2'b00);
        step(1'b0);
        @(negedge clk);
        check("t5_err_set", bus.err_unexp_rsp, 1);
        step(1'b0);
        @(negedge clk);
        check("t5_err_sticky", bus.err_unexp_rsp, 1);
        step(1'b0);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_err_clr", bus.err_unexp_rsp, 0);

        // Reset with 3 reads outstanding and m1 locked
        auto_rsp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            bus.m0_read = 1; bus.m0_address = 32'h800 + 32'(4 * i);
            @(negedge clk);
            check("t6_pre_wait", bus.m0_waitrequest, 0);
        end
        step(1'b0);
        bus.m0_read = 0;
        bus.m1_read = 1; bus.m1_address = 32'h900;
        bus.s_waitrequest = 1;
        @(negedge clk);
        check("t6_lock_addr", bus.s_address, 32'h900);
        step(1'b0);
        rst = 1'b1;
        bus.m1_read = 0; bus.s_waitrequest = 0;
        step(1'b0);
        rst = 1'b0;
        slv_q.delete();
        lg = 1'b1; k0 = 0; k1 = 0;
        for (int i = 0; i < 4; i++) begin
            a0 = 32'hA00 + 32'(4 * k0);
            a1 = 32'hB00 + 32'(4 * k1);
            bus.m0_read = 1; bus.m0_address = a0;
            bus.m1_read = 1; bus.m1_address = a1;
            @(negedge clk);
            g = ~lg;
            check("t6_addr", bus.s_address, g ? a1 : a0);
            check("t6_waits", {bus.m1_waitrequest, bus.m0_waitrequest}, g ? 2'b01 : 2'b10);
            sb_q.push_back('{g, rdat(g ? a1 : a0)});
            if (g) k1++; else k0++;
            lg = g;
            step(1'b0);
        end
        bus.m0_address = 32'hA00 + 32'(4 * k0);
        bus.m1_address = 32'hB00 + 32'(4 * k1);
        @(negedge clk);
        check("t6_full_waits", {bus.m1_waitrequest, bus.m0_waitrequest}, 2'b11);
        check("t6_full_s_read", bus.s_read, 0);
        auto_rsp = 1'b1;
        step(1'b0);
        bus.m0_read = 0; bus.m1_read = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
